// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter
//   Round-robin arbiter and timing sequencer that shares one bank of DW
//   transparent d/en latches between NREQ requesters. Each transaction runs
//   IDLE -> SETUP -> OPEN -> HOLD -> IDLE so that lat_d is stable for
//   SETUP_CYC cycles before lat_en rises, for OPEN_CYC cycles with lat_en
//   high, and for HOLD_CYC cycles after lat_en falls.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset (aborts a transaction at once)
//   req     in   [NREQ]    per-requester level request, held until done
//   wdata   in   [NREQ*DW] requester i data at [i*DW +: DW]
//   lat_q   in   [DW]      latch bank readback (LATCH_READBACK_EN only)
//   grant   out  [NREQ]    one-hot current owner, 0 when idle
//   done    out  [NREQ]    one-cycle completion pulse in the last HOLD cycle
//   lat_d   out  [DW]      latch bank data
//   lat_en  out            latch bank enable
//   busy    out            high in any state other than IDLE
//   err     out            sticky readback mismatch flag
//
// Build option
//   LATCH_READBACK_EN : compare lat_q against lat_d in the first HOLD cycle
//                       and set err on mismatch. Undefined: err is tied 0.
module latch_bank_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned OPEN_CYC  = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [DW-1:0]      lat_q,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      lat_d,
  output logic               lat_en,
  output logic               busy,
  output logic               err
);

  localparam int unsigned PW   = $clog2(NREQ);
  localparam int unsigned MAX1 = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
  localparam int unsigned MAXC = (MAX1 > HOLD_CYC) ? MAX1 : HOLD_CYC;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_OPEN, S_HOLD} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic [DW-1:0]   r_lat_d;
  logic            r_lat_en;
  logic            r_busy;

  logic            w_found;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_sel;
  logic [DW-1:0]   w_slice;
  logic [PW-1:0]   w_ptr_nxt;

  // First set request scanning upward from the pointer, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = PW'((32'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_slice = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_sel == PW'(i)) w_slice = wdata[i*DW +: DW];
    end
  end

  assign w_ptr_nxt = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_lat_d  <= '0;
      r_lat_en <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_SETUP;
            r_cnt   <= CW'(SETUP_CYC - 1);
            r_grant <= NREQ'(1) << w_sel;
            r_owner <= w_sel;
            r_lat_d <= w_slice;
            r_busy  <= 1'b1;
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_state  <= S_OPEN;
            r_cnt    <= CW'(OPEN_CYC - 1);
            r_lat_en <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_OPEN: begin
          if (r_cnt == '0) begin
            r_state  <= S_HOLD;
            r_cnt    <= CW'(HOLD_CYC - 1);
            r_lat_en <= 1'b0;
            // done is registered, so it is raised on entry to the last HOLD cycle
            if (HOLD_CYC == 1) r_done <= r_grant;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_done <= r_grant;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LATCH_READBACK_EN
  logic r_err;

  // Readback is checked once, in the first HOLD cycle, after the bank has closed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == S_HOLD && r_cnt == CW'(HOLD_CYC - 1) && lat_q != r_lat_d) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_lat_q;
  assign w_unused_lat_q = ^lat_q;
  assign err = 1'b0;
`endif

  assign grant  = r_grant;
  assign done   = r_done;
  assign lat_d  = r_lat_d;
  assign lat_en = r_lat_en;
  assign busy   = r_busy;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed bench for latch_bank_arbiter with default parameters.
module tb_latch_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [7:0]  lat_q;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  lat_d;
  logic        lat_en;
  logic        busy;
  logic        err;

  logic        q_force;
  logic        exp_err;
  int          n_cmp  = 0;
  int          n_fail = 0;

  // Latch bank model: q follows d unless forced to a stuck-at-zero value.
  assign lat_q = q_force ? 8'h00 : lat_d;

  always #5 clk = ~clk;

  latch_bank_arbiter #(
    .NREQ(4), .DW(8), .SETUP_CYC(1), .OPEN_CYC(2), .HOLD_CYC(1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .lat_q(lat_q),
    .grant(grant), .done(done), .lat_d(lat_d), .lat_en(lat_en),
    .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks one transaction from the cycle after the granting edge (step 1)
  // to the IDLE cycle (step 5). Two optional req edits at chosen steps.
  task automatic txn(input int idx, input logic [7:0] data,
                     input int sa, input logic [3:0] clr_a, input logic [3:0] set_a,
                     input int sb, input logic [3:0] clr_b, input logic [3:0] set_b);
    logic [3:0] g;
    g = 4'b0001 << idx;
    for (int s = 1; s <= 5; s++) begin
      @(negedge clk);
`ifdef LATCH_READBACK_EN
      if (s == 5 && q_force && data != 8'h00) exp_err = 1'b1;
`endif
      check($sformatf("t%0d_s%0d_grant", idx, s), grant, (s == 5) ? 4'b0000 : g);
      check($sformatf("t%0d_s%0d_lat_en", idx, s), lat_en, (s == 2 || s == 3) ? 1 : 0);
      check($sformatf("t%0d_s%0d_done", idx, s), done, (s == 4) ? g : 4'b0000);
      check($sformatf("t%0d_s%0d_busy", idx, s), busy, (s != 5) ? 1 : 0);
      check($sformatf("t%0d_s%0d_lat_d", idx, s), lat_d, data);
      check($sformatf("t%0d_s%0d_err", idx, s), err, exp_err);
      if (s == 2) wdata[idx*8 +: 8] = ~data;
      if (s == 5) wdata[idx*8 +: 8] = data;
      if (s == sa) req = (req & ~clr_a) | set_a;
      if (s == sb) req = (req & ~clr_b) | set_b;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; wdata = '0; q_force = 1'b0; exp_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 4'b0000);
    check("rst_done", done, 4'b0000);
    check("rst_lat_en", lat_en, 1'b0);
    check("rst_lat_d", lat_d, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;

    // Single write from requester 2
    wdata = 32'h00A5_0000; req = 4'b0100;
    txn(2, 8'hA5, 4, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000);

    // Pointer now 3: req 0101 wraps to 0, then skips to 2
    wdata = 32'h0011_0022; req = 4'b0101;
    txn(0, 8'h22, 4, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000);
    txn(2, 8'h11, 4, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000);

    // Reset mid-OPEN aborts; pointer 3 scans 3,0,1 -> grant 1
    wdata = 32'h0000_4400; req = 4'b0010;
    @(negedge clk);
    check("ab_grant", grant, 4'b0010);
    @(negedge clk);
    check("ab_open", lat_en, 1'b1);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("ab%0d_lat_en", c), lat_en, 1'b0);
      check($sformatf("ab%0d_grant", c), grant, 4'b0000);
      check($sformatf("ab%0d_busy", c), busy, 1'b0);
      check($sformatf("ab%0d_done", c), done, 4'b0000);
      check($sformatf("ab%0d_lat_d", c), lat_d, 8'h00);
      req = 4'b0000;
    end
    rst = 1'b0;
    wdata = 32'h0000_0077; req = 4'b0001;
    txn(0, 8'h77, 4, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000);

    // Reset pointer to 0, then round robin with drop/re-raise
    rst = 1'b1;
    @(negedge clk);
    check("rr_rst_busy", busy, 1'b0);
    rst = 1'b0;
    wdata = 32'hD3C2_B1A0; req = 4'b1111;
    txn(0, 8'hA0, 4, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000);
    txn(1, 8'hB1, 1, 4'b0000, 4'b0001, 4, 4'b0010, 4'b0000);
    txn(2, 8'hC2, 1, 4'b0000, 4'b0010, 4, 4'b0100, 4'b0000);
    txn(3, 8'hD3, 1, 4'b0000, 4'b0100, 4, 4'b1000, 4'b0000);
    txn(0, 8'hA0, 1, 4'b0000, 4'b1000, 4, 4'b0001, 4'b0000);
    req = 4'b0000;

    // Owner abandons during OPEN; another requester raises during OPEN
    wdata[15:8] = 8'h5A; req = 4'b0010;
    txn(1, 8'h5A, 2, 4'b0010, 4'b1000, 0, 4'b0000, 4'b0000);
    txn(3, 8'hD3, 4, 4'b1000, 4'b0000, 0, 4'b0000, 4'b0000);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("idle%0d_grant", c), grant, 4'b0000);
      check($sformatf("idle%0d_busy", c), busy, 1'b0);
    end

    // Readback: stuck-at-zero q, then a good write; err is sticky until rst
    wdata[7:0] = 8'h3C; q_force = 1'b1; req = 4'b0001;
    txn(0, 8'h3C, 4, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000);
    q_force = 1'b0;
    wdata[23:16] = 8'hA5; req = 4'b0100;
    txn(2, 8'hA5, 4, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000);
    rst = 1'b1; exp_err = 1'b0;
    @(negedge clk);
    check("end_err", err, exp_err);
    check("end_busy", busy, 1'b0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/latch_bank_arbiter.md
Name: latch_bank_arbiter

Overview:
- Round-robin arbiter and timing sequencer that shares one bank of DW transparent D-latches (d/en style) between NREQ requesters.
- Grants one requester at a time and drives the bank's data and enable lines with guaranteed setup, open and hold windows, so d never changes while en is high.
- Sits between requester logic and the latch bank. It is the only driver of the bank's d/en.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, latch bank data width
- SETUP_CYC, 1, cycles lat_d is stable before lat_en rises (>=1)
- OPEN_CYC, 2, cycles lat_en stays high (>=1)
- HOLD_CYC, 1, cycles lat_d is held after lat_en falls (>=1)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester write request; level, held until done
- wdata  input  NREQ*DW  requester i data at bits [i*DW +: DW]
- lat_q  input  DW  latch bank q readback (used only with LATCH_READBACK_EN)
- grant  output  NREQ  one-hot current owner, 0 when idle
- done  output  NREQ  one-cycle completion pulse to owner
- lat_d  output  DW  latch bank d
- lat_en  output  1  latch bank enable
- busy  output  1  high in any state other than IDLE
- err  output  1  sticky readback mismatch flag

Behaviour:
- Reset (sync, rst=1 at a rising edge): state=IDLE, grant=0, done=0, lat_d=0, lat_en=0, busy=0, err=0, rr pointer=0.
- rst asserted mid-transaction aborts immediately. lat_en is 0 from the next edge and no done pulse is issued.
- All outputs are registered.
- FSM: IDLE -> SETUP -> OPEN -> HOLD -> IDLE. One down-counter is reloaded on each state entry.
- IDLE:
  - If any req is set, pick the first set bit scanning from rr pointer upward with wrap (pointer=2, req=4'b1011 -> grant 3).
  - Register grant, capture wdata slice into lat_d, go to SETUP.
  - If no req is set, stay in IDLE.
- SETUP: SETUP_CYC cycles, lat_en=0, lat_d stable.
- OPEN: OPEN_CYC cycles, lat_en=1, lat_d stable.
- HOLD: HOLD_CYC cycles, lat_en=0, lat_d stable. done[owner]=1 in the last HOLD cycle only.
- Leaving HOLD: grant=0, rr pointer = owner+1 mod NREQ, state=IDLE.
- lat_d changes only on entry to SETUP from IDLE, never while lat_en=1.
- Latency: req seen in IDLE at edge t gives:
  - grant valid at t+1
  - lat_en high t+1+SETUP_CYC .. t+SETUP_CYC+OPEN_CYC
  - done in cycle t+SETUP_CYC+OPEN_CYC+HOLD_CYC
  - back in IDLE one cycle later
  - Defaults: 5 cycles per transaction, minimum 1 IDLE cycle between transactions.
- Requester rules: keep req and wdata stable until done, then drop req on the next cycle.
  - wdata changes after capture are ignored.
  - req dropped mid-transaction is ignored; the transaction completes and done still pulses.
- Non-owners' req are ignored until IDLE. Simultaneous new req during a transaction is queued by level only.
- Pointer wraps NREQ-1 -> 0. A single persistent requester is granted back-to-back.

Optional Feature:
- Macro LATCH_READBACK_EN.
- Defined:
  - In the first HOLD cycle, compare lat_q to lat_d.
  - On mismatch set err=1 (sticky until rst).
  - done still pulses.
- Undefined: lat_q is ignored, err is tied 0, no compare logic.

Test Plan:
- Reset check: rst=1 for 2 cycles mid-OPEN -> next edge lat_en=0, grant=0, busy=0, no done. Then req=4'b0001 -> full sequence restarts with grant=4'b0001.
- Single write: req=4'b0100, wdata slice2=8'hA5 -> grant=4'b0100 at t+1, lat_d=8'hA5, lat_en high t+2..t+3, done[2] at t+4, IDLE at t+5.
- Round robin: req=4'b1111 held, each requester drops req after its done and re-raises 2 cycles later -> grant order 0,1,2,3,0. No lat_d change while lat_en=1.
- Wrap and skip: pointer=3 after a grant to 2, req=4'b0101 -> grant 0 then 2.
- Late/abandon: owner drops req during OPEN -> done still pulses in HOLD. A new req from another requester raised during OPEN -> granted in the following IDLE.
- LATCH_READBACK_EN defined: lat_q forced to 8'h00 while lat_d=8'h3C -> err=1 after first HOLD cycle and stays 1 through later good writes until rst.
